ucsbece154a_controller_mw: RTL and testbench
============================================

Name: ucsbece154a_controller_mw

Overview:
Multicycle RV32I-subset main controller, next generation. Adds a memory ready/request handshake with wait states, an optional BNE, LUI writeback, a parametrised memory timeout, and a sticky illegal-instruction/fault state. It sits between the instruction register and the datapath and drives every datapath select, enable and ALU control.

Parameters:
SUPPORT_BNE, 1, 1: funct3=001 on branch opcode is BNE; 0: that encoding is illegal
MEM_TIMEOUT, 16, max consecutive wait cycles in a memory state before fault; 0 disables the timeout
TOCNT_W, 5, timeout counter width; must satisfy 2^TOCNT_W > MEM_TIMEOUT

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op_i  in  7  IR opcode
funct3_i  in  3  IR funct3
funct7_i  in  1  IR bit 30
zero_i  in  1  ALU zero flag
mem_ready_i  in  1  memory completes the access this cycle
mem_req_o  out  1  memory access request
PCWrite_o  out  1  PC enable
MemWrite_o  out  1  memory write strobe
IRWrite_o  out  1  IR enable
RegWrite_o  out  1  register file write
ALUSrcA_o  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB_o  out  2  00 RD2, 01 ImmExt, 10 const 4
AdrSrc_o  out  1  0 PC, 1 Result
ResultSrc_o  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
ALUControl_o  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc_o  out  3  000 I, 001 S, 010 B, 011 J, 100 U
fault_o  out  1  sticky illegal-opcode/timeout flag

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. On reset the next edge sets state=Fetch, fault_o=0 and the timeout counter to 0. All registered outputs are loaded with their Fetch values. Reset overrides a fault and an in-flight access.
- Control registers: state, control register set, ALUOp. Each loads from its next-state decode every edge. ImmSrc_o and ALUControl_o are combinational from op/funct/ALUOp. ALUControl_o follows the existing decode. ImmSrc_o is x for R-type and illegal opcodes.
- States and transitions:
  - Fetch -> Decode, only on a cycle with mem_ready_i=1; otherwise stay in Fetch.
  - Decode -> by opcode:
    - lw/sw -> MemAdr
    - R -> ExecR
    - I-ALU -> ExecI
    - branch -> Branch
    - jal -> JAL
    - lui (0110111) -> LUI
    - any other opcode -> Fault
  - MemAdr -> MemRead (lw) or MemWrite (sw).
  - MemRead -> MemWB when mem_ready_i=1; otherwise stay.
  - MemWrite -> Fetch when mem_ready_i=1; otherwise stay.
  - ExecR/ExecI/JAL -> ALUWB.
  - MemWB, ALUWB, Branch, LUI -> Fetch.
  - Fault -> Fault until reset.
- Memory states (Fetch, MemRead, MemWrite): mem_req_o=1 throughout the state.
  - MemWrite_o is asserted for the whole MemWrite state.
  - Only the completion cycle updates architectural state:
    - IRWrite_o = IRWrite_q & mem_ready_i
    - PCWrite_o = (PCUpdate_q & (~memstate | mem_ready_i)) | (Branch_q & taken)
- Branch: taken = zero_i for funct3=000 and ~zero_i for funct3=001 (when SUPPORT_BNE=1). Any other funct3 goes to Fault from Decode.
- LUI state: RegWrite=1, ResultSrc=11, ImmSrc=100. Single cycle, then Fetch.
- JAL state: PCUpdate=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=00, ALUOp=00.
- Timeout counter:
  - Increments each cycle spent in a memory state with mem_ready_i=0.
  - Clears on any state change.
  - When it reaches MEM_TIMEOUT (MEM_TIMEOUT≠0), the next state is Fault.
  - If mem_ready_i=1 in the same cycle the limit is reached, completion wins.
- Fault: all enables/strobes are 0, mem_req_o=0, fault_o=1 (sticky).
- Unsupported ALU funct3 in ExecR/ExecI: ALUControl_o=xxx. No fault is raised for this.

Decomposition:
- Shared package (existing defines header):
  - opcode/funct3 constants, including instr_bne_funct3 and instr_lui_op
  - state encodings (4-bit), including state_Fault
  - ALUcontrol_* and ALUop_* constants
  - ResultSrc/ImmSrc select constants
- Natural sub-module ucsbece154a_aludec: combinational ALUOp/funct3/funct7/op -> ALUControl_o.

Test Plan:
1. add x3,x1,x2, mem_ready_i always 1 -> Fetch, Decode, ExecR, ALUWB, Fetch. ALUControl_o=000 in ExecR. RegWrite_o=1 for exactly 1 cycle.
2. lw with mem_ready_i low 3 cycles in MemRead -> stays in MemRead 4 cycles. IRWrite_o=0 and PCWrite_o=0 throughout. Then MemWB with ResultSrc_o=01 and RegWrite_o=1.
3. bne with zero_i=0 -> PCWrite_o=1 in Branch. With zero_i=1 -> PCWrite_o=0. Repeat with SUPPORT_BNE=0 -> Fault, fault_o=1.
4. lui x5,0x12345 -> LUI state: ImmSrc_o=100, ResultSrc_o=11, RegWrite_o=1; then Fetch 1 cycle later.
5. MEM_TIMEOUT=4, mem_ready_i held 0 in Fetch -> Fault after 4 wait cycles, fault_o=1, mem_req_o=0. Second run with ready at the 4th cycle -> Decode, no fault.
6. Reset asserted mid-MemWrite -> next edge: state Fetch, MemWrite_o=0, fault_o=0, timeout counter 0.

Source files
------------

// File: rtl/ucsbece154a_controller_mw_pkg.sv
// Shared constants for the multicycle RV32I-subset controller.
// Holds opcode/funct3 encodings, ALU control and ALUOp codes, datapath select codes, the 4-bit
// controller state encoding, the registered control bundle and its per-state decode.
package ucsbece154a_controller_mw_pkg;

  // Opcodes
  localparam logic [6:0] InstrLwOp     = 7'b0000011;
  localparam logic [6:0] InstrSwOp     = 7'b0100011;
  localparam logic [6:0] InstrRtypeOp  = 7'b0110011;
  localparam logic [6:0] InstrItypeOp  = 7'b0010011;
  localparam logic [6:0] InstrBranchOp = 7'b1100011;
  localparam logic [6:0] InstrJalOp    = 7'b1101111;
  localparam logic [6:0] InstrLuiOp    = 7'b0110111;

  // funct3 encodings
  localparam logic [2:0] InstrBeqFunct3    = 3'b000;
  localparam logic [2:0] InstrBneFunct3    = 3'b001;
  localparam logic [2:0] InstrAddsubFunct3 = 3'b000;
  localparam logic [2:0] InstrSltFunct3    = 3'b010;
  localparam logic [2:0] InstrOrFunct3     = 3'b110;
  localparam logic [2:0] InstrAndFunct3    = 3'b111;

  // ALU control
  localparam logic [2:0] AluCtrlAdd = 3'b000;
  localparam logic [2:0] AluCtrlSub = 3'b001;
  localparam logic [2:0] AluCtrlAnd = 3'b010;
  localparam logic [2:0] AluCtrlOr  = 3'b011;
  localparam logic [2:0] AluCtrlSlt = 3'b101;

  // ALUOp
  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  // Datapath selects
  localparam logic [1:0] SrcAPc     = 2'b00;
  localparam logic [1:0] SrcAOldPc  = 2'b01;
  localparam logic [1:0] SrcARd1    = 2'b10;
  localparam logic [1:0] SrcBRd2    = 2'b00;
  localparam logic [1:0] SrcBImm    = 2'b01;
  localparam logic [1:0] SrcBFour   = 2'b10;
  localparam logic [1:0] ResAluOut  = 2'b00;
  localparam logic [1:0] ResData    = 2'b01;
  localparam logic [1:0] ResAluRes  = 2'b10;
  localparam logic [1:0] ResImm     = 2'b11;
  localparam logic [2:0] ImmTypeI   = 3'b000;
  localparam logic [2:0] ImmTypeS   = 3'b001;
  localparam logic [2:0] ImmTypeB   = 3'b010;
  localparam logic [2:0] ImmTypeJ   = 3'b011;
  localparam logic [2:0] ImmTypeU   = 3'b100;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWrite = 4'd4,
    StMemWB    = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StALUWB    = 4'd8,
    StBranch   = 4'd9,
    StJAL      = 4'd10,
    StLUI      = 4'd11,
    StFault    = 4'd12
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       pc_update;
    logic       branch;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] alu_op;
  } ctrl_t;

  // Control values that must be presented while in state s.
  function automatic ctrl_t ctrl_of(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      StFetch: begin
        c.mem_req    = 1'b1;
        c.ir_write   = 1'b1;
        c.pc_update  = 1'b1;
        c.alu_src_a  = SrcAPc;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluRes;
        c.alu_op     = AluOpAdd;
      end
      StDecode: begin
        c.alu_src_a = SrcAOldPc;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluOpAdd;
      end
      StMemAdr: begin
        c.alu_src_a = SrcARd1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluOpAdd;
      end
      StMemRead: begin
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.result_src = ResAluOut;
      end
      StMemWrite: begin
        c.mem_req    = 1'b1;
        c.adr_src    = 1'b1;
        c.mem_write  = 1'b1;
        c.result_src = ResAluOut;
      end
      StMemWB: begin
        c.reg_write  = 1'b1;
        c.result_src = ResData;
      end
      StExecR: begin
        c.alu_src_a = SrcARd1;
        c.alu_src_b = SrcBRd2;
        c.alu_op    = AluOpFunct;
      end
      StExecI: begin
        c.alu_src_a = SrcARd1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluOpFunct;
      end
      StALUWB: begin
        c.reg_write  = 1'b1;
        c.result_src = ResAluOut;
      end
      StBranch: begin
        c.branch     = 1'b1;
        c.alu_src_a  = SrcARd1;
        c.alu_src_b  = SrcBRd2;
        c.alu_op     = AluOpSub;
        c.result_src = ResAluOut;
      end
      StJAL: begin
        c.pc_update  = 1'b1;
        c.alu_src_a  = SrcAOldPc;
        c.alu_src_b  = SrcBFour;
        c.result_src = ResAluOut;
        c.alu_op     = AluOpAdd;
      end
      StLUI: begin
        c.reg_write  = 1'b1;
        c.result_src = ResImm;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ucsbece154a_aludec.sv
// ALU decoder: maps ALUOp plus instruction funct fields to the ALU control code.
// Ports: ALUOp_i (00 add, 01 sub, 10 by funct), funct3_i, funct7_i (IR bit 30), op5_i (IR bit 5,
// distinguishes R-type from I-type), ALUControl_o.
module ucsbece154a_aludec
  import ucsbece154a_controller_mw_pkg::*;
(
  input  logic [1:0] ALUOp_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       op5_i,
  output logic [2:0] ALUControl_o
);

  always_comb begin
    ALUControl_o = 3'bxxx;
    case (ALUOp_i)
      AluOpAdd: ALUControl_o = AluCtrlAdd;
      AluOpSub: ALUControl_o = AluCtrlSub;
      AluOpFunct: begin
        case (funct3_i)
          // Only R-type honours bit 30; addi never subtracts.
          InstrAddsubFunct3: ALUControl_o = (funct7_i & op5_i) ? AluCtrlSub : AluCtrlAdd;
          InstrSltFunct3:    ALUControl_o = AluCtrlSlt;
          InstrOrFunct3:     ALUControl_o = AluCtrlOr;
          InstrAndFunct3:    ALUControl_o = AluCtrlAnd;
          default:           ALUControl_o = 3'bxxx;
        endcase
      end
      default: ALUControl_o = 3'bxxx;
    endcase
  end

endmodule

// File: rtl/ucsbece154a_controller_mw.sv
// Multicycle main controller with memory ready/request handshake, wait-state timeout, optional
// BNE, LUI writeback and a sticky fault state.
// Ports: clk/reset (sync active-high); op_i/funct3_i/funct7_i from IR; zero_i ALU flag;
// mem_ready_i completes the current access; mem_req_o, PCWrite_o, MemWrite_o, IRWrite_o,
// RegWrite_o enables; ALUSrcA_o/ALUSrcB_o/AdrSrc_o/ResultSrc_o selects; ALUControl_o and ImmSrc_o
// combinational decodes; fault_o sticky fault flag.
module ucsbece154a_controller_mw
  import ucsbece154a_controller_mw_pkg::*;
#(
  parameter bit          SUPPORT_BNE = 1'b1,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TOCNT_W     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       PCWrite_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       RegWrite_o,
  output logic [1:0] ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       AdrSrc_o,
  output logic [1:0] ResultSrc_o,
  output logic [2:0] ALUControl_o,
  output logic [2:0] ImmSrc_o,
  output logic       fault_o
);

  state_e               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [TOCNT_W-1:0]   to_cnt_q, to_cnt_d;
  logic                 fault_q, fault_d;
  logic                 mem_wait;
  logic                 timeout;
  logic                 taken;

  // mem_req is set exactly in the memory states, so it doubles as the memory-state flag.
  assign mem_wait = ctrl_q.mem_req & ~mem_ready_i;
  // Fires on the wait cycle that would bring the count up to the limit.
  assign timeout  = mem_wait && (MEM_TIMEOUT != 0) &&
                    ((32'(to_cnt_q) + 32'd1) == MEM_TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StFetch;
      ctrl_q   <= ctrl_of(StFetch);
      to_cnt_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      to_cnt_q <= to_cnt_d;
      fault_q  <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        case (op_i)
          InstrLwOp, InstrSwOp: state_d = StMemAdr;
          InstrRtypeOp:         state_d = StExecR;
          InstrItypeOp:         state_d = StExecI;
          InstrJalOp:           state_d = StJAL;
          InstrLuiOp:           state_d = StLUI;
          InstrBranchOp: begin
            if (funct3_i == InstrBeqFunct3 || (SUPPORT_BNE && funct3_i == InstrBneFunct3)) begin
              state_d = StBranch;
            end else begin
              state_d = StFault;
            end
          end
          default:              state_d = StFault;
        endcase
      end
      StMemAdr:   state_d = (op_i == InstrLwOp) ? StMemRead : StMemWrite;
      StMemRead:  if (mem_ready_i) state_d = StMemWB;
      StMemWrite: if (mem_ready_i) state_d = StFetch;
      StExecR, StExecI, StJAL:             state_d = StALUWB;
      StMemWB, StALUWB, StBranch, StLUI:   state_d = StFetch;
      default:                             state_d = StFault;
    endcase
    if (timeout) state_d = StFault;

    if (state_d != state_q) begin
      to_cnt_d = '0;
    end else if (mem_wait) begin
      to_cnt_d = to_cnt_q + TOCNT_W'(1);
    end else begin
      to_cnt_d = to_cnt_q;
    end

    ctrl_d  = ctrl_of(state_d);
    fault_d = (state_d == StFault);
  end

  always_comb begin
    taken = 1'b0;
    if (funct3_i == InstrBeqFunct3) begin
      taken = zero_i;
    end else if (SUPPORT_BNE && funct3_i == InstrBneFunct3) begin
      taken = ~zero_i;
    end

    mem_req_o   = ctrl_q.mem_req;
    // Architectural state only moves on the completing cycle of a memory access.
    IRWrite_o   = ctrl_q.ir_write & mem_ready_i;
    PCWrite_o   = (ctrl_q.pc_update & (~ctrl_q.mem_req | mem_ready_i)) | (ctrl_q.branch & taken);
    MemWrite_o  = ctrl_q.mem_write;
    RegWrite_o  = ctrl_q.reg_write;
    ALUSrcA_o   = ctrl_q.alu_src_a;
    ALUSrcB_o   = ctrl_q.alu_src_b;
    AdrSrc_o    = ctrl_q.adr_src;
    ResultSrc_o = ctrl_q.result_src;
    fault_o     = fault_q;

    ImmSrc_o = 3'bxxx;
    case (op_i)
      InstrLwOp, InstrItypeOp: ImmSrc_o = ImmTypeI;
      InstrSwOp:               ImmSrc_o = ImmTypeS;
      InstrBranchOp:           ImmSrc_o = ImmTypeB;
      InstrJalOp:              ImmSrc_o = ImmTypeJ;
      InstrLuiOp:              ImmSrc_o = ImmTypeU;
      default:                 ImmSrc_o = 3'bxxx;
    endcase
  end

  ucsbece154a_aludec u_aludec (
    .ALUOp_i      (ctrl_q.alu_op),
    .funct3_i     (funct3_i),
    .funct7_i     (funct7_i),
    .op5_i        (op_i[5]),
    .ALUControl_o (ALUControl_o)
  );

endmodule

// File: tb/tb_ucsbece154a_controller_mw.sv
// Bench for the multicycle controller. Two instances share inputs: index 0 uses the default
// parameters, index 1 has BNE disabled and a 4-cycle memory timeout.
module tb_ucsbece154a_controller_mw;

  typedef enum int {
    MFetch, MDecode, MMemAdr, MMemRead, MMemWrite, MMemWB, MExecR, MExecI, MAluWB,
    MBranch, MJal, MLui, MFault
  } mst_e;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBr  = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;
  localparam logic [6:0] OpLui = 7'b0110111;

  logic       clk, reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7, zero, ready;

  logic       mem_req [2];
  logic       pc_write [2];
  logic       mem_write [2];
  logic       ir_write [2];
  logic       reg_write [2];
  logic [1:0] alu_src_a [2];
  logic [1:0] alu_src_b [2];
  logic       adr_src [2];
  logic [1:0] result_src [2];
  logic [2:0] alu_ctrl [2];
  logic [2:0] imm_src [2];
  logic       fault [2];

  int checks = 0;
  int errors = 0;

  ucsbece154a_controller_mw u_dut (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .mem_ready_i(ready), .mem_req_o(mem_req[0]), .PCWrite_o(pc_write[0]),
    .MemWrite_o(mem_write[0]), .IRWrite_o(ir_write[0]), .RegWrite_o(reg_write[0]),
    .ALUSrcA_o(alu_src_a[0]), .ALUSrcB_o(alu_src_b[0]), .AdrSrc_o(adr_src[0]),
    .ResultSrc_o(result_src[0]), .ALUControl_o(alu_ctrl[0]), .ImmSrc_o(imm_src[0]),
    .fault_o(fault[0])
  );

  ucsbece154a_controller_mw #(
    .SUPPORT_BNE(1'b0), .MEM_TIMEOUT(4), .TOCNT_W(3)
  ) u_dut_nb (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .mem_ready_i(ready), .mem_req_o(mem_req[1]), .PCWrite_o(pc_write[1]),
    .MemWrite_o(mem_write[1]), .IRWrite_o(ir_write[1]), .RegWrite_o(reg_write[1]),
    .ALUSrcA_o(alu_src_a[1]), .ALUSrcB_o(alu_src_b[1]), .AdrSrc_o(adr_src[1]),
    .ResultSrc_o(result_src[1]), .ALUControl_o(alu_ctrl[1]), .ImmSrc_o(imm_src[1]),
    .fault_o(fault[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Expected {req, pcwrite, memwrite, irwrite, regwrite, srcA, srcB, adrsrc, resultsrc, fault}.
  function automatic logic [12:0] exp_vec(mst_e s, logic rdy, logic z, logic [2:0] f3, bit bne);
    logic req, pcw, mw, irw, rw, adr, flt, tk;
    logic [1:0] sa, sb, rs;
    req = 0; pcw = 0; mw = 0; irw = 0; rw = 0; adr = 0; flt = 0; sa = 0; sb = 0; rs = 0;
    tk = (f3 == 3'd0) ? z : ((bne && f3 == 3'd1) ? ~z : 1'b0);
    case (s)
      MFetch:    begin req = 1; irw = rdy; pcw = rdy; sb = 2; rs = 2; end
      MDecode:   begin sa = 1; sb = 1; end
      MMemAdr:   begin sa = 2; sb = 1; end
      MMemRead:  begin req = 1; adr = 1; end
      MMemWrite: begin req = 1; adr = 1; mw = 1; end
      MMemWB:    begin rs = 1; rw = 1; end
      MExecR:    sa = 2;
      MExecI:    begin sa = 2; sb = 1; end
      MAluWB:    rw = 1;
      MBranch:   begin sa = 2; pcw = tk; end
      MJal:      begin sa = 1; sb = 2; pcw = 1; end
      MLui:      begin rw = 1; rs = 3; end
      default:   flt = 1;
    endcase
    return {req, pcw, mw, irw, rw, sa, sb, adr, rs, flt};
  endfunction

  // {defined, code}: add outside the execute/branch states, funct-decoded in execute.
  function automatic logic [3:0] exp_alu(mst_e s, logic [6:0] o, logic [2:0] f3, logic f7);
    logic [3:0] r;
    r = 4'b1000;
    if (s == MBranch) r = 4'b1001;
    else if (s == MExecR || s == MExecI) begin
      case (f3)
        3'd0:    r = (o[5] && f7) ? 4'b1001 : 4'b1000;
        3'd2:    r = 4'b1101;
        3'd6:    r = 4'b1011;
        3'd7:    r = 4'b1010;
        default: r = 4'b0000;
      endcase
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_imm(logic [6:0] o);
    if (o == OpLw || o == OpI) return 4'b1000;
    if (o == OpSw)  return 4'b1001;
    if (o == OpBr)  return 4'b1010;
    if (o == OpJal) return 4'b1011;
    if (o == OpLui) return 4'b1100;
    return 4'b0000;
  endfunction

  function automatic mst_e decode_next(logic [6:0] o, logic [2:0] f3, bit bne);
    if (o == OpLw || o == OpSw) return MMemAdr;
    if (o == OpR)   return MExecR;
    if (o == OpI)   return MExecI;
    if (o == OpJal) return MJal;
    if (o == OpLui) return MLui;
    if (o == OpBr && (f3 == 3'd0 || (bne && f3 == 3'd1))) return MBranch;
    return MFault;
  endfunction

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_req[i], fault[i], mem_write[i], reg_write[i]} !== 4'b1000) begin
        errors++;
        $display("FAIL reset_state dut%0d got=%b want=1000", i,
                 {mem_req[i], fault[i], mem_write[i], reg_write[i]});
      end
      checks++;
      if ({ir_write[i], pc_write[i]} !== 2'b00) begin
        errors++;
        $display("FAIL reset_noready dut%0d got=%b want=00", i, {ir_write[i], pc_write[i]});
      end
    end
    ready = 1'b1;
    #1;
    checks++;
    if ({ir_write[0], pc_write[0]} !== 2'b11) begin
      errors++;
      $display("FAIL reset_fetch_done got=%b want=11", {ir_write[0], pc_write[0]});
    end
  endtask

  task automatic test_rtype();
    int rw_cycles;
    do_reset();
    op = OpR; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; ready = 1'b1;
    #1;
    rw_cycles = int'(reg_write[0]);
    checks++;
    if ({mem_req[0], ir_write[0], pc_write[0]} !== 3'b111) begin
      errors++;
      $display("FAIL rtype_fetch got=%b want=111", {mem_req[0], ir_write[0], pc_write[0]});
    end
    step();
    rw_cycles += int'(reg_write[0]);
    checks++;
    if (mem_req[0] !== 1'b0) begin
      errors++; $display("FAIL rtype_decode_req got=%b want=0", mem_req[0]);
    end
    step();
    rw_cycles += int'(reg_write[0]);
    checks++;
    if ({alu_ctrl[0], alu_src_a[0], alu_src_b[0]} !== 7'b000_10_00) begin
      errors++;
      $display("FAIL rtype_exec got=%b want=0001000", {alu_ctrl[0], alu_src_a[0], alu_src_b[0]});
    end
    funct7 = 1'b1;
    #1;
    checks++;
    if (alu_ctrl[0] !== 3'b001) begin
      errors++; $display("FAIL rtype_sub got=%b want=001", alu_ctrl[0]);
    end
    funct7 = 1'b0;
    step();
    rw_cycles += int'(reg_write[0]);
    checks++;
    if ({reg_write[0], result_src[0]} !== 3'b100) begin
      errors++; $display("FAIL rtype_aluwb got=%b want=100", {reg_write[0], result_src[0]});
    end
    step();
    rw_cycles += int'(reg_write[0]);
    checks++;
    if (mem_req[0] !== 1'b1 || rw_cycles != 1) begin
      errors++;
      $display("FAIL rtype_done req=%b regwrite_cycles=%0d want req=1 cycles=1",
               mem_req[0], rw_cycles);
    end
  endtask

  task automatic test_lw_wait();
    do_reset();
    op = OpLw; funct3 = 3'd2; funct7 = 1'b0; ready = 1'b1;
    step();
    step();
    checks++;
    if ({alu_src_a[0], alu_src_b[0]} !== 4'b1001) begin
      errors++; $display("FAIL lw_memadr got=%b want=1001", {alu_src_a[0], alu_src_b[0]});
    end
    step();
    for (int k = 0; k < 4; k++) begin
      ready = (k == 3);
      #1;
      checks++;
      if ({mem_req[0], adr_src[0], ir_write[0], pc_write[0]} !== 4'b1100) begin
        errors++;
        $display("FAIL lw_memread_wait%0d got=%b want=1100", k,
                 {mem_req[0], adr_src[0], ir_write[0], pc_write[0]});
      end
      step();
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({result_src[i], reg_write[i], fault[i]} !== 4'b0110) begin
        errors++;
        $display("FAIL lw_memwb dut%0d got=%b want=0110", i,
                 {result_src[i], reg_write[i], fault[i]});
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    op = OpBr; funct3 = 3'd1; zero = 1'b0; ready = 1'b1;
    step();
    step();
    #1;
    checks++;
    if (pc_write[0] !== 1'b1) begin
      errors++; $display("FAIL bne_taken got=%b want=1", pc_write[0]);
    end
    checks++;
    if ({fault[1], mem_req[1], pc_write[1]} !== 3'b100) begin
      errors++;
      $display("FAIL bne_unsupported got=%b want=100", {fault[1], mem_req[1], pc_write[1]});
    end
    zero = 1'b1;
    #1;
    checks++;
    if (pc_write[0] !== 1'b0) begin
      errors++; $display("FAIL bne_not_taken got=%b want=0", pc_write[0]);
    end
    step();
    checks++;
    if ({mem_req[0], fault[1], mem_req[1]} !== 3'b110) begin
      errors++;
      $display("FAIL bne_after got=%b want=110", {mem_req[0], fault[1], mem_req[1]});
    end
  endtask

  task automatic test_lui();
    do_reset();
    op = OpLui; ready = 1'b1;
    step();
    step();
    checks++;
    if ({imm_src[0], result_src[0], reg_write[0]} !== 6'b100_11_1) begin
      errors++;
      $display("FAIL lui_state got=%b want=100111", {imm_src[0], result_src[0], reg_write[0]});
    end
    step();
    checks++;
    if ({mem_req[0], reg_write[0]} !== 2'b10) begin
      errors++; $display("FAIL lui_to_fetch got=%b want=10", {mem_req[0], reg_write[0]});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    op = OpR; funct3 = 3'd0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({fault[1], mem_req[1]} !== 2'b01) begin
        errors++; $display("FAIL timeout_wait%0d got=%b want=01", k, {fault[1], mem_req[1]});
      end
      step();
    end
    checks++;
    if ({fault[1], mem_req[1], ir_write[1], fault[0], mem_req[0]} !== 5'b10001) begin
      errors++;
      $display("FAIL timeout_fault got=%b want=10001",
               {fault[1], mem_req[1], ir_write[1], fault[0], mem_req[0]});
    end
    do_reset();
    checks++;
    if (fault[1] !== 1'b0) begin
      errors++; $display("FAIL timeout_reset_clears got=%b want=0", fault[1]);
    end
    for (int k = 0; k < 4; k++) begin
      ready = (k == 3);
      #1;
      checks++;
      if (ir_write[1] !== (k == 3)) begin
        errors++; $display("FAIL timeout_edge_irw%0d got=%b want=%b", k, ir_write[1], k == 3);
      end
      step();
    end
    checks++;
    if ({fault[1], mem_req[1], alu_src_a[1]} !== 4'b0001) begin
      errors++;
      $display("FAIL timeout_edge_decode got=%b want=0001", {fault[1], mem_req[1], alu_src_a[1]});
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    op = OpSw; funct3 = 3'd2; ready = 1'b1;
    step();
    step();
    step();
    ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({mem_write[0], mem_req[0], adr_src[0]} !== 3'b111) begin
        errors++;
        $display("FAIL sw_memwrite%0d got=%b want=111", k, {mem_write[0], mem_req[0], adr_src[0]});
      end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({mem_write[i], fault[i], mem_req[i], adr_src[i]} !== 4'b0010) begin
        errors++;
        $display("FAIL reset_mid_write dut%0d got=%b want=0010", i,
                 {mem_write[i], fault[i], mem_req[i], adr_src[i]});
      end
    end
    step();
    step();
    step();
    checks++;
    if (fault[1] !== 1'b0) begin
      errors++; $display("FAIL reset_cnt_cleared got=%b want=0", fault[1]);
    end
    step();
    checks++;
    if (fault[1] !== 1'b1) begin
      errors++; $display("FAIL reset_cnt_limit got=%b want=1", fault[1]);
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [7];
    logic [2:0]  f3s [5];
    mst_e        m_state [2];
    mst_e        n_state [2];
    int          m_cnt [2];
    int          n_cnt [2];
    int unsigned m_to [2];
    bit          m_bne [2];
    int          pct;
    ops = '{OpLw, OpSw, OpR, OpI, OpBr, OpJal, OpLui};
    f3s = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    m_to = '{16, 4};
    m_bne = '{1'b1, 1'b0};
    pct = 80;
    do_reset();
    m_state = '{MFetch, MFetch};
    m_cnt = '{0, 0};
    for (int c = 0; c < 3000; c++) begin
      int idx;
      if (c % 50 == 0) pct = (pct == 80) ? 25 : 80;
      reset = ($urandom_range(0, 31) == 0);
      idx = int'($urandom_range(0, 7));
      op = (idx == 7) ? 7'($urandom) : ops[idx];
      funct3 = ($urandom_range(0, 1) == 0) ? f3s[$urandom_range(0, 4)] : 3'($urandom);
      funct7 = 1'($urandom);
      zero = 1'($urandom);
      ready = (int'($urandom_range(0, 99)) < pct);
      #1;
      for (int i = 0; i < 2; i++) begin
        logic [12:0] ev, ov;
        logic [3:0]  ea, ei;
        bit          memst, waiting;
        ev = exp_vec(m_state[i], ready, zero, funct3, m_bne[i]);
        ov = {mem_req[i], pc_write[i], mem_write[i], ir_write[i], reg_write[i], alu_src_a[i],
              alu_src_b[i], adr_src[i], result_src[i], fault[i]};
        checks++;
        if (ov !== ev) begin
          errors++;
          $display("FAIL rand_ctrl dut%0d cyc%0d got=%b want=%b", i, c, ov, ev);
        end
        ea = exp_alu(m_state[i], op, funct3, funct7);
        if (ea[3]) begin
          checks++;
          if (alu_ctrl[i] !== ea[2:0]) begin
            errors++;
            $display("FAIL rand_aluctrl dut%0d cyc%0d got=%b want=%b", i, c, alu_ctrl[i], ea[2:0]);
          end
        end
        ei = exp_imm(op);
        if (ei[3]) begin
          checks++;
          if (imm_src[i] !== ei[2:0]) begin
            errors++;
            $display("FAIL rand_immsrc dut%0d cyc%0d got=%b want=%b", i, c, imm_src[i], ei[2:0]);
          end
        end
        memst = (m_state[i] == MFetch || m_state[i] == MMemRead || m_state[i] == MMemWrite);
        waiting = memst && !ready;
        case (m_state[i])
          MFetch:    n_state[i] = ready ? MDecode : MFetch;
          MDecode:   n_state[i] = decode_next(op, funct3, m_bne[i]);
          MMemAdr:   n_state[i] = (op == OpLw) ? MMemRead : MMemWrite;
          MMemRead:  n_state[i] = ready ? MMemWB : MMemRead;
          MMemWrite: n_state[i] = ready ? MFetch : MMemWrite;
          MExecR, MExecI, MJal: n_state[i] = MAluWB;
          MFault:    n_state[i] = MFault;
          default:   n_state[i] = MFetch;
        endcase
        if (waiting && m_to[i] != 0 && m_cnt[i] + 1 == int'(m_to[i])) n_state[i] = MFault;
        if (n_state[i] != m_state[i]) n_cnt[i] = 0;
        else n_cnt[i] = waiting ? m_cnt[i] + 1 : m_cnt[i];
        if (reset) begin
          n_state[i] = MFetch;
          n_cnt[i] = 0;
        end
      end
      step();
      m_state = n_state;
      m_cnt = n_cnt;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; op = OpR; funct3 = 3'd0; funct7 = 1'b0; zero = 1'b0; ready = 1'b0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_branch();
    test_lui();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
